// File: rtl/delay_prgrm_tx_if.sv
// Command/serial bundle for the delay-line programming serializer.
// Host side uses the master modport and the serializer uses the slave modport.
interface delay_prgrm_tx_if #(
  parameter int unsigned D_DEPTH = 3
);
  logic               req;
  logic [1:0]         line_sel;
  logic [D_DEPTH-1:0] delay_val;
  logic               abort;
  logic               ack;
  logic               busy;
  logic               done;
  logic               aborted;
  logic               prgrm_go_;
  logic               prgrm_in;

  modport master (
    output req, line_sel, delay_val, abort,
    input  ack, busy, done, aborted, prgrm_go_, prgrm_in
  );

  modport slave (
    input  req, line_sel, delay_val, abort,
    output ack, busy, done, aborted, prgrm_go_, prgrm_in
  );
endinterface

// File: rtl/delay_prgrm_tx.sv
// Host-side serializer for the delay-line programming interface.
// Captures {delay_val, line_sel, write bit} on a req edge and shifts it out
// LSB first while prgrm_go_ is held low, then keeps prgrm_go_ high for a gap
// so the receiver is back in IDLE before the next frame.
// Optional macro PRGRM_ABORT_EN enables cutting a frame short with abort.
module delay_prgrm_tx #(
  parameter int unsigned D_DEPTH = 3,
  parameter int unsigned GAP_CYC = 2
) (
  input logic              clk,
  input logic              rst_,
  delay_prgrm_tx_if.slave  bus
);

  localparam int unsigned FRAME_LEN = 3 + D_DEPTH;
  localparam int unsigned CNT_W = ($clog2(FRAME_LEN) > 3) ? $clog2(FRAME_LEN) : 3;
  localparam int unsigned GAP_W = ($clog2(GAP_CYC) > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state;
  logic [FRAME_LEN-1:0] shreg;
  logic [CNT_W-1:0]     bit_cnt;
  logic [GAP_W-1:0]     gap_cnt;

`ifndef PRGRM_ABORT_EN
  logic unused_abort;
  assign unused_abort = bus.abort;
`endif

  // Frame sequencer: capture, shift, end-of-frame gap; all outputs registered.
  // The IDLE cycle after the gap counts as the last prgrm_go_-high cycle, so
  // GAP lasts GAP_CYC-1 cycles and is skipped entirely when GAP_CYC is 1.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      bus.prgrm_go_ <= 1'b1;
      bus.prgrm_in  <= 1'b0;
      bus.ack       <= 1'b0;
      bus.done      <= 1'b0;
      bus.aborted   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.ack     <= 1'b0;
      bus.done    <= 1'b0;
      bus.aborted <= 1'b0;
      case (state)
        IDLE: begin
          bus.prgrm_go_ <= 1'b1;
          bus.prgrm_in  <= 1'b0;
          bus.busy      <= 1'b0;
          if (bus.req) begin
            shreg         <= {bus.delay_val, bus.line_sel, 1'b0};
            bus.prgrm_go_ <= 1'b0;
            bus.prgrm_in  <= 1'b0;
            bus.ack       <= 1'b1;
            bus.busy      <= 1'b1;
            bit_cnt       <= '0;
            state         <= SEND;
          end
        end
        SEND: begin
          if (bit_cnt == LAST_BIT) begin
            bus.prgrm_go_ <= 1'b1;
            bus.prgrm_in  <= 1'b0;
            bus.done      <= 1'b1;
            gap_cnt       <= GAP_LOAD;
            if (GAP_CYC > 1) begin
              state <= GAP;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
`ifdef PRGRM_ABORT_EN
          else if (bus.abort) begin
            bus.prgrm_go_ <= 1'b1;
            bus.prgrm_in  <= 1'b0;
            bus.aborted   <= 1'b1;
            gap_cnt       <= GAP_LOAD;
            if (GAP_CYC > 1) begin
              state <= GAP;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
`endif
          else begin
            shreg        <= shreg >> 1;
            bus.prgrm_in <= shreg[1];
            bit_cnt      <= bit_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          bus.prgrm_go_ <= 1'b1;
          bus.prgrm_in  <= 1'b0;
          if (gap_cnt == GAP_W'(1)) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_prgrm_tx.sv
// Directed bench for delay_prgrm_tx (default D_DEPTH=3, GAP_CYC=2).
module tb_delay_prgrm_tx;

`ifdef PRGRM_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif

  logic clk;
  logic rst_;
  int   checks;
  int   errors;

  delay_prgrm_tx_if #(.D_DEPTH(3)) bus ();

  delay_prgrm_tx #(.D_DEPTH(3), .GAP_CYC(2)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic go, input logic din,
                          input logic ack, input logic done, input logic ab,
                          input logic busy);
    chk({tag, " go"},      bus.prgrm_go_, go);
    chk({tag, " in"},      bus.prgrm_in,  din);
    chk({tag, " ack"},     bus.ack,       ack);
    chk({tag, " done"},    bus.done,      done);
    chk({tag, " aborted"}, bus.aborted,   ab);
    chk({tag, " busy"},    bus.busy,      busy);
  endtask

  // One frame starting at the next edge; checks every cycle up to the next
  // earliest accept edge (8 cycles) or until back in IDLE after an abort.
  task automatic frame(input string name, input logic [1:0] ls, input logic [2:0] dv,
                       input bit drop_req, input bit mutate, input bit do_abort);
    logic [5:0] bits;
    bit         cut;
    int         n;
    logic       e_go, e_in, e_done, e_ab, e_busy, e_ack;
    bits = {dv, ls, 1'b0};
    cut  = do_abort && ABORT_ON;
    n    = cut ? 6 : 8;
    bus.req       = 1'b1;
    bus.line_sel  = ls;
    bus.delay_val = dv;
    for (int k = 0; k < n; k++) begin
      tick();
      if (k == 0 && drop_req) bus.req = 1'b0;
      if (k == 2 && mutate) begin
        bus.line_sel  = ~ls;
        bus.delay_val = ~dv;
      end
      if (k == 3 && do_abort) bus.abort = 1'b1;
      if (k == 4 && do_abort) bus.abort = 1'b0;
      if (cut && k >= 4) begin
        e_go   = 1'b1;
        e_in   = 1'b0;
        e_done = 1'b0;
        e_ab   = (k == 4);
        e_busy = (k == 4);
      end else begin
        e_go   = (k < 6) ? 1'b0 : 1'b1;
        e_in   = (k < 6) ? bits[3'(k)] : 1'b0;
        e_done = (k == 6);
        e_ab   = 1'b0;
        e_busy = (k < 7);
      end
      e_ack = (k == 0);
      chk_outs($sformatf("%s k=%0d", name, k), e_go, e_in, e_ack, e_done, e_ab, e_busy);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_          = 1'b0;
    bus.req       = 1'b0;
    bus.line_sel  = 2'd0;
    bus.delay_val = 3'd0;
    bus.abort     = 1'b0;

    // Reset state
    tick();
    tick();
    chk_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_ = 1'b1;

    // Idle with no request
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_outs($sformatf("idle%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Single frame: line 2, delay 5 -> bits 0,0,1,1,0,1
    frame("f25", 2'd2, 3'd5, 1'b1, 1'b0, 1'b0);

    // Back-to-back with req held: three frames at the minimum period
    frame("c37a", 2'd3, 3'd7, 1'b0, 1'b0, 1'b0);
    frame("c37b", 2'd3, 3'd7, 1'b0, 1'b0, 1'b0);
    frame("c37c", 2'd3, 3'd7, 1'b1, 1'b0, 1'b0);

    // Inputs changed mid-frame must not affect the captured command
    frame("mut", 2'd1, 3'd2, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a frame
    bus.req       = 1'b1;
    bus.line_sel  = 2'd2;
    bus.delay_val = 3'd3;
    tick();
    bus.req = 1'b0;
    chk("rstmid ack", bus.ack, 1'b1);
    tick();
    tick();
    tick();
    rst_ = 1'b0;
    tick();
    chk_outs("rstmid", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_ = 1'b1;
    tick();
    chk_outs("rstidle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame("postrst", 2'd1, 3'd6, 1'b1, 1'b0, 1'b0);

    // Abort raised during the bit-3 cycle
    frame("abort", 2'd2, 3'd5, 1'b1, 1'b0, 1'b1);

    // A clean frame after the abort scenario
    frame("final", 2'd0, 3'd4, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
